// File: rtl/axi_wr_dispatch_arb.sv
// Write dispatcher: arbitrates AXI and loader beats onto the FIFO, IRAM and WRAM targets, one beat in flight.
// Optional ISSUE timeout is enabled by defining WR_DISPATCH_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no beat in flight; round-robin grant when AXI pend or ld_req
// S_ISSUE | driving the granted target until ack / FIFO space (or timeout)
// S_DONE  | one-cycle done pulse to the granted requester
module axi_wr_dispatch_arb #(
    parameter int AW     = 11,
    parameter int DW     = 32,
    parameter int SW     = 4,
    parameter int TO_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          axi_wr_vld,
    input  logic [AW-1:0] axi_wr_addr,
    input  logic [DW-1:0] axi_wr_data,
    input  logic [SW-1:0] axi_wr_strb,
    input  logic [1:0]    axi_wr_region,
    output logic          fifo_wr_done,
    output logic          iram_wr_done,
    output logic          wram_wr_done,
    output logic          axi_wr_err,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [SW-1:0] ld_strb,
    input  logic [1:0]    ld_region,
    output logic          ld_done,
    output logic          ld_err,
    output logic          fifo_we,
    output logic [DW-1:0] fifo_wdata,
    input  logic          fifo_full,
    output logic          iram_req,
    output logic [AW-1:0] iram_addr,
    output logic [DW-1:0] iram_wdata,
    output logic [SW-1:0] iram_wstrb,
    input  logic          iram_ack,
    output logic          wram_req,
    output logic [AW-1:0] wram_addr,
    output logic [DW-1:0] wram_wdata,
    output logic [SW-1:0] wram_wstrb,
    input  logic          wram_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] RG_FIFO = 2'b00;
    localparam logic [1:0] RG_IRAM = 2'b01;
    localparam logic [1:0] RG_WRAM = 2'b10;
    localparam logic [1:0] RG_ILL  = 2'b11;

`ifdef WR_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int            TW      = ($clog2(TO_CYC) > 8) ? $clog2(TO_CYC) : 8;
    localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC - 1);

    state_t        state;
    logic          pend;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [SW-1:0] pend_strb;
    logic [1:0]    pend_region;
    logic          gnt_ld;
    logic          last_gnt_ld;
    logic [1:0]    tgt;
    logic [TW-1:0] to_cnt;

    logic          sel_ld;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [SW-1:0] sel_strb;
    logic [1:0]    sel_region;
    logic          issue_ok;
    logic          to_hit;
    logic          enter_done;
    logic          done_ld;
    logic          done_err;
    logic [1:0]    done_rg;

    always_comb begin
        // On a tie the loader wins only if the AXI side was served last.
        sel_ld     = ld_req & (~pend | ~last_gnt_ld);
        sel_addr   = sel_ld ? ld_addr   : pend_addr;
        sel_data   = sel_ld ? ld_data   : pend_data;
        sel_strb   = sel_ld ? ld_strb   : pend_strb;
        sel_region = sel_ld ? ld_region : pend_region;

        issue_ok = 1'b0;
        case (tgt)
            RG_FIFO: issue_ok = ~fifo_full;
            RG_IRAM: issue_ok = iram_ack;
            RG_WRAM: issue_ok = wram_ack;
            default: issue_ok = 1'b0;
        endcase
        to_hit = TO_EN && (to_cnt == '0);

        enter_done = 1'b0;
        done_ld    = gnt_ld;
        done_rg    = tgt;
        done_err   = ~issue_ok;
        if (state == S_IDLE) begin
            done_ld    = sel_ld;
            done_rg    = sel_region;
            done_err   = 1'b1;
            enter_done = (pend | ld_req) && (sel_region == RG_ILL);
        end else if (state == S_ISSUE) begin
            enter_done = issue_ok | to_hit;
        end
    end

    // The push must see fifo_full in the same cycle, so the strobe is decoded from state rather than registered.
    assign fifo_we = (state == S_ISSUE) && (tgt == RG_FIFO) && !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pend         <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            pend_strb    <= '0;
            pend_region  <= '0;
            gnt_ld       <= 1'b0;
            last_gnt_ld  <= 1'b1;
            tgt          <= '0;
            to_cnt       <= '0;
            fifo_wr_done <= 1'b0;
            iram_wr_done <= 1'b0;
            wram_wr_done <= 1'b0;
            axi_wr_err   <= 1'b0;
            ld_done      <= 1'b0;
            ld_err       <= 1'b0;
            fifo_wdata   <= '0;
            iram_req     <= 1'b0;
            iram_addr    <= '0;
            iram_wdata   <= '0;
            iram_wstrb   <= '0;
            wram_req     <= 1'b0;
            wram_addr    <= '0;
            wram_wdata   <= '0;
            wram_wstrb   <= '0;
        end else begin
            fifo_wr_done <= 1'b0;
            iram_wr_done <= 1'b0;
            wram_wr_done <= 1'b0;
            axi_wr_err   <= 1'b0;
            ld_done      <= 1'b0;
            ld_err       <= 1'b0;

            if (axi_wr_vld && !pend) begin
                pend        <= 1'b1;
                pend_addr   <= axi_wr_addr;
                pend_data   <= axi_wr_data;
                pend_strb   <= axi_wr_strb;
                pend_region <= axi_wr_region;
            end

            if (enter_done) begin
                iram_req <= 1'b0;
                wram_req <= 1'b0;
                state    <= S_DONE;
                if (done_ld) begin
                    ld_done <= 1'b1;
                    ld_err  <= done_err;
                end else begin
                    axi_wr_err <= done_err;
                    case (done_rg)
                        RG_IRAM: iram_wr_done <= 1'b1;
                        RG_WRAM: wram_wr_done <= 1'b1;
                        default: fifo_wr_done <= 1'b1;
                    endcase
                end
            end

            case (state)
                S_IDLE: begin
                    if (pend | ld_req) begin
                        gnt_ld <= sel_ld;
                        tgt    <= sel_region;
                        if (sel_region != RG_ILL) begin
                            state  <= S_ISSUE;
                            to_cnt <= TO_LOAD;
                            case (sel_region)
                                RG_IRAM: begin
                                    iram_req   <= 1'b1;
                                    iram_addr  <= sel_addr;
                                    iram_wdata <= sel_data;
                                    iram_wstrb <= sel_strb;
                                end
                                RG_WRAM: begin
                                    wram_req   <= 1'b1;
                                    wram_addr  <= sel_addr;
                                    wram_wdata <= sel_data;
                                    wram_wstrb <= sel_strb;
                                end
                                default: fifo_wdata <= sel_data;
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    if (!enter_done && (to_cnt != '0)) begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    last_gnt_ld <= gnt_ld;
                    if (!gnt_ld) begin
                        pend <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_dispatch_arb.sv
// Bench for axi_wr_dispatch_arb: directed cases plus random traffic against a transaction-level reference model.
// Timeout expectations follow WR_DISPATCH_TIMEOUT_EN when it is defined for the build.
module tb_axi_wr_dispatch_arb;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO_CYC = 64;
`ifdef WR_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic axi_wr_vld = 1'b0;
    logic [AW-1:0] axi_wr_addr = '0;
    logic [DW-1:0] axi_wr_data = '0;
    logic [SW-1:0] axi_wr_strb = '0;
    logic [1:0] axi_wr_region = '0;
    logic fifo_wr_done, iram_wr_done, wram_wr_done, axi_wr_err;
    logic ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [SW-1:0] ld_strb = '0;
    logic [1:0] ld_region = '0;
    logic ld_done, ld_err;
    logic fifo_we;
    logic [DW-1:0] fifo_wdata;
    logic fifo_full = 1'b0;
    logic iram_req, wram_req;
    logic [AW-1:0] iram_addr, wram_addr;
    logic [DW-1:0] iram_wdata, wram_wdata;
    logic [SW-1:0] iram_wstrb, wram_wstrb;
    logic iram_ack = 1'b0;
    logic wram_ack = 1'b0;

    always #5 clk = ~clk;

    axi_wr_dispatch_arb #(.AW(AW), .DW(DW), .SW(SW), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .axi_wr_vld(axi_wr_vld), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
        .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
        .fifo_wr_done(fifo_wr_done), .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done),
        .axi_wr_err(axi_wr_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_strb(ld_strb), .ld_region(ld_region),
        .ld_done(ld_done), .ld_err(ld_err),
        .fifo_we(fifo_we), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .iram_req(iram_req), .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_wstrb(iram_wstrb),
        .iram_ack(iram_ack),
        .wram_req(wram_req), .wram_addr(wram_addr), .wram_wdata(wram_wdata), .wram_wstrb(wram_wstrb),
        .wram_ack(wram_ack)
    );

    typedef struct packed {
        logic [1:0]    rg;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus controls: ack/full mode 0 random, 1 forced high, 2 forced low
    bit rst_go = 1'b1, axi_go = 1'b0, ld_go = 1'b0;
    beat_t axi_nb, ld_nb;
    int ack_mode = 0, full_mode = 0;

    // reference model: outstanding beats per requester and the beat being served
    bit a_out = 0, l_out = 0, busy = 0, w_ld = 0, w_err = 0, last_ld = 1;
    beat_t a_beat, l_beat, w;
    int a_elig = 0, l_elig = 0, free_at = 0, issue_start = 0, done_at = -1;
    int done_log[$];
    int we_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic beat_t mk_beat(input logic [1:0] rg, input logic [AW-1:0] a,
                                      input logic [DW-1:0] d, input logic [SW-1:0] s);
        beat_t b;
        b.rg = rg; b.addr = a; b.data = d; b.strb = s;
        return b;
    endfunction

    function automatic beat_t rand_beat(input bit allow_ill);
        logic [1:0] rg;
        rg = (allow_ill && $urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return mk_beat(rg, AW'($urandom), $urandom, SW'($urandom));
    endfunction

    function automatic logic pick(input int m);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return ($urandom_range(0, 1) == 1);
    endfunction

    // Expected outputs of the current cycle from the dispatch rules, then advance the model.
    task automatic model_step();
        logic e_we, e_ir, e_wr, e_fd, e_id, e_wd, e_ae, e_ld, e_le;
        bit cond, ae, le;
        int n;
        {e_we, e_ir, e_wr, e_fd, e_id, e_wd, e_ae, e_ld, e_le} = '0;
        cond = 1'b0;
        if (busy && cyc == done_at) begin
            if (w_ld) begin
                e_ld = 1'b1; e_le = w_err; l_out = 0;
            end else begin
                a_out = 0; e_ae = w_err;
                case (w.rg)
                    2'b01: e_id = 1'b1;
                    2'b10: e_wd = 1'b1;
                    default: e_fd = 1'b1;
                endcase
            end
            last_ld = w_ld; busy = 0; free_at = cyc + 1;
        end else if (busy && done_at < 0) begin
            n = cyc - issue_start + 1;
            case (w.rg)
                2'b01: begin
                    e_ir = 1'b1; cond = iram_ack;
                    chk("iram_addr", 64'(iram_addr), 64'(w.addr));
                    chk("iram_wdata", 64'(iram_wdata), 64'(w.data));
                    chk("iram_wstrb", 64'(iram_wstrb), 64'(w.strb));
                end
                2'b10: begin
                    e_wr = 1'b1; cond = wram_ack;
                    chk("wram_addr", 64'(wram_addr), 64'(w.addr));
                    chk("wram_wdata", 64'(wram_wdata), 64'(w.data));
                    chk("wram_wstrb", 64'(wram_wstrb), 64'(w.strb));
                end
                default: begin
                    e_we = !fifo_full; cond = !fifo_full;
                    if (!fifo_full) chk("fifo_wdata", 64'(fifo_wdata), 64'(w.data));
                end
            endcase
            if (cond) begin
                done_at = cyc + 1; w_err = 0;
            end else if (TO_EN && n == TO_CYC) begin
                done_at = cyc + 1; w_err = 1;
            end
        end
        chk("ctl", 64'({fifo_we, iram_req, wram_req, fifo_wr_done, iram_wr_done, wram_wr_done,
                        axi_wr_err, ld_done, ld_err}),
                   64'({e_we, e_ir, e_wr, e_fd, e_id, e_wd, e_ae, e_ld, e_le}));
        if (!busy && cyc >= free_at) begin
            ae = a_out && a_elig <= cyc;
            le = l_out && l_elig <= cyc;
            if (ae || le) begin
                w_ld = le && (!ae || !last_ld);
                w = w_ld ? l_beat : a_beat;
                busy = 1;
                if (w.rg == 2'b11) begin
                    done_at = cyc + 1; w_err = 1;
                end else begin
                    issue_start = cyc + 1; done_at = -1;
                end
            end
        end
        if (rst) begin
            busy = 0; a_out = 0; l_out = 0; last_ld = 1; free_at = cyc + 1; done_at = -1;
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_go;
        axi_wr_vld = 1'b0;
        if (rst_go) begin
            ld_req = 1'b0;
        end else begin
            if (axi_go && !a_out) begin
                axi_wr_vld = 1'b1;
                axi_wr_region = axi_nb.rg; axi_wr_addr = axi_nb.addr;
                axi_wr_data = axi_nb.data; axi_wr_strb = axi_nb.strb;
                a_out = 1; a_beat = axi_nb; a_elig = cyc + 1; axi_go = 0;
            end
            if (!l_out) begin
                if (ld_go) begin
                    ld_req = 1'b1;
                    ld_region = ld_nb.rg; ld_addr = ld_nb.addr;
                    ld_data = ld_nb.data; ld_strb = ld_nb.strb;
                    l_out = 1; l_beat = ld_nb; l_elig = cyc; ld_go = 0;
                end else begin
                    ld_req = 1'b0;
                end
            end
        end
        iram_ack = pick(ack_mode);
        wram_ack = pick(ack_mode);
        fifo_full = (full_mode == 0) ? ($urandom_range(0, 9) < 3) : (full_mode == 1);
        @(negedge clk);
        if (fifo_we) we_cnt++;
        if (ld_done) done_log.push_back(1);
        if (fifo_wr_done || iram_wr_done || wram_wr_done) done_log.push_back(0);
        model_step();
    endtask

    task automatic do_reset();
        rst_go = 1; axi_go = 0; ld_go = 0;
        repeat (2) run_cycle();
        rst_go = 0;
    endtask

    initial begin
        int cnt, we0, na, nl;
        bit seen_done, seen_err;

        // reset state
        do_reset();
        chk("rst_ctl", 64'({fifo_we, iram_req, wram_req, fifo_wr_done, iram_wr_done, wram_wr_done,
                            axi_wr_err, ld_done, ld_err}), 64'd0);
        chk("rst_iram_addr", 64'(iram_addr), 64'd0);
        chk("rst_fifo_wdata", 64'(fifo_wdata), 64'd0);

        // AXI IRAM beat, ack already high in the first ISSUE cycle
        ack_mode = 1; full_mode = 2;
        axi_nb = mk_beat(2'b01, 11'h010, 32'hDEADBEEF, 4'hF); axi_go = 1;
        run_cycle(); chk("b_req_t0", 64'(iram_req), 64'd0);
        run_cycle(); chk("b_req_t1", 64'(iram_req), 64'd0);
        run_cycle(); chk("b_req_t2", 64'(iram_req), 64'd1);
        chk("b_addr", 64'(iram_addr), 64'h010);
        chk("b_data", 64'(iram_wdata), 64'hDEADBEEF);
        run_cycle(); chk("b_done_t3", 64'(iram_wr_done), 64'd1);
        chk("b_err", 64'(axi_wr_err), 64'd0);
        chk("b_req_t3", 64'(iram_req), 64'd0);

        // AXI FIFO beat with the FIFO full for five ISSUE cycles
        do_reset();
        full_mode = 1; we0 = we_cnt;
        axi_nb = mk_beat(2'b00, 11'h123, 32'h1234_5678, 4'h3); axi_go = 1;
        repeat (7) run_cycle();
        chk("c_we_full", 64'(fifo_we), 64'd0);
        full_mode = 2;
        run_cycle(); chk("c_we", 64'(fifo_we), 64'd1);
        chk("c_wdata", 64'(fifo_wdata), 64'h1234_5678);
        run_cycle(); chk("c_done", 64'(fifo_wr_done), 64'd1);
        chk("c_we_count", 64'(we_cnt - we0), 64'd1);

        // both requesters pending from reset: AXI first, then strict alternation
        do_reset();
        ack_mode = 1; full_mode = 2; done_log.delete();
        axi_nb = rand_beat(0); axi_go = 1; na = 1;
        run_cycle();
        ld_nb = rand_beat(0); ld_go = 1; nl = 1;
        for (int i = 0; i < 300 && done_log.size() < 8; i++) begin
            if (!axi_go && !a_out && na < 4) begin axi_nb = rand_beat(0); axi_go = 1; na++; end
            if (!ld_go && !l_out && nl < 4) begin ld_nb = rand_beat(0); ld_go = 1; nl++; end
            run_cycle();
        end
        chk("d_beats", 64'(done_log.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < done_log.size(); i++) chk("d_order", 64'(done_log[i]), 64'(i % 2));

        // illegal region from both requesters
        do_reset();
        axi_nb = mk_beat(2'b11, 11'h7FF, 32'hCAFE_0001, 4'h1); axi_go = 1;
        repeat (3) run_cycle();
        chk("e_axi_done", 64'({fifo_wr_done, axi_wr_err}), 64'b11);
        ld_nb = mk_beat(2'b11, 11'h001, 32'hCAFE_0002, 4'h2); ld_go = 1;
        repeat (2) run_cycle();
        chk("e_ld_done", 64'({ld_done, ld_err}), 64'b11);

        // WRAM ack withheld
        do_reset();
        ack_mode = 2; cnt = 0; seen_done = 0; seen_err = 0;
        axi_nb = mk_beat(2'b10, 11'h055, 32'h0BAD_F00D, 4'hA); axi_go = 1;
        repeat (210) begin
            run_cycle();
            if (wram_req) cnt++;
            if (wram_wr_done) begin seen_done = 1; seen_err = axi_wr_err; end
        end
`ifdef WR_DISPATCH_TIMEOUT_EN
        chk("f_req_cycles", 64'(cnt), 64'(TO_CYC));
        chk("f_done", 64'(seen_done), 64'd1);
        chk("f_err", 64'(seen_err), 64'd1);
`else
        chk("f_req_cycles", 64'(cnt), 64'd208);
        chk("f_done", 64'(seen_done), 64'd0);
`endif
        ack_mode = 1;
        repeat (3) run_cycle();

        // reset in the middle of an IRAM ISSUE
        do_reset();
        ack_mode = 2;
        axi_nb = mk_beat(2'b01, 11'h200, 32'h5555_AAAA, 4'h5); axi_go = 1;
        repeat (4) run_cycle();
        chk("g_req_before", 64'(iram_req), 64'd1);
        rst_go = 1; run_cycle(); rst_go = 0;
        done_log.delete();
        run_cycle(); chk("g_req_after", 64'(iram_req), 64'd0);
        repeat (5) run_cycle();
        chk("g_no_done", 64'(done_log.size()), 64'd0);
        ack_mode = 1;
        axi_nb = rand_beat(0); axi_go = 1;
        run_cycle();
        ld_nb = rand_beat(0); ld_go = 1;
        for (int i = 0; i < 40 && done_log.size() < 2; i++) run_cycle();
        chk("g_beats", 64'(done_log.size() >= 2), 64'd1);
        if (done_log.size() > 0) chk("g_axi_first", 64'(done_log[0]), 64'd0);

        // random traffic
        do_reset();
        ack_mode = 0; full_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!axi_go && !a_out && $urandom_range(0, 3) == 0) begin axi_nb = rand_beat(1); axi_go = 1; end
            if (!ld_go && !l_out && $urandom_range(0, 3) == 0) begin ld_nb = rand_beat(1); ld_go = 1; end
            rst_go = ($urandom_range(0, 299) == 0);
            run_cycle();
        end
        rst_go = 0;
        repeat (5) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
